mem_dump_streamer: RTL and testbench



---
 rtl/mem_dump_streamer_pkg.sv | 24 ++
 rtl/mem_dump_streamer_if.sv | 32 +++
 rtl/mem_dump_streamer_strobe_pacer.sv | 50 +++++
 rtl/mem_dump_streamer.sv | 131 +++++++++++++
 tb/tb_mem_dump_streamer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dump_streamer_pkg.sv
// Shared types and helpers for the memory dump streamer.
// State encoding, counter widths and the stop-length test.
package mem_dump_streamer_pkg;

  localparam int CNT_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_SETUP = 3'd3,
    S_HIGH  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  function automatic logic is_last(
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] max_len
  );
    return (cnt + CNT_W'(1)) == max_len;
  endfunction

endpackage

// File: rtl/mem_dump_streamer_if.sv
// Port-2 memory bus plus the Arduino byte/strobe bus.
// master = streamer side, slave = memory/receiver side.
interface mem_dump_streamer_if
  import mem_dump_streamer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [BYTE_W-1:0] out_data;
  logic              out_strobe;

  modport master (
    output mem_rd_en,
    output mem_addr,
    output out_data,
    output out_strobe,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    input  out_data,
    input  out_strobe,
    output mem_rdata
  );

endinterface

// File: rtl/mem_dump_streamer_strobe_pacer.sv
// Down-counter producing a setup window (strobe low)
// followed by a high window (strobe high) after each go.
module strobe_pacer
  import mem_dump_streamer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         go,
  input  logic [W-1:0] setup_len,
  input  logic [W-1:0] high_len,
  output logic         strobe,
  output logic         finished
);

  logic [W-1:0] cnt;
  logic         in_setup;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt      <= '0;
      in_setup <= 1'b0;
      strobe   <= 1'b0;
    end else if (go) begin
      cnt      <= setup_len - W'(1);
      in_setup <= 1'b1;
      strobe   <= 1'b0;
    end else if (in_setup) begin
      if (cnt == '0) begin
        in_setup <= 1'b0;
        strobe   <= 1'b1;
        cnt      <= high_len - W'(1);
      end else begin
        cnt <= cnt - W'(1);
      end
    end else if (strobe) begin
      if (cnt == '0) begin
        strobe <= 1'b0;
      end else begin
        cnt <= cnt - W'(1);
      end
    end
  end

  // High during the last strobe-high cycle.
  assign finished = strobe && (cnt == '0);

endmodule

// File: rtl/mem_dump_streamer.sv
// Walks DataMemory port 2 from a base address and streams
// the low byte of each word to the Arduino bus until NUL.
module mem_dump_streamer
  import mem_dump_streamer_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_LEN   = 1024,
  parameter int ADDR_STEP = 1,
  parameter int SETUP_CYC = 4,
  parameter int HIGH_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  mem_dump_streamer_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  byte_count
);

  localparam logic [CNT_W-1:0] MAX_L =
    CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] SETUP_L =
    CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] HIGH_L =
    CNT_W'(HIGH_CYC);
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(ADDR_STEP);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] rdata;
  logic [BYTE_W-1:0] rd_byte;
  logic              kill;
  logic              go;
  logic              strobe;
  logic              finished;

  assign rdata     = bus.mem_rdata;
  assign rd_byte   = rdata[BYTE_W-1:0];
  assign next_addr = addr + STEP;
  assign kill      = abort && (state != S_IDLE);
  assign go        = (state == S_WAIT) && !kill &&
                     (rd_byte != '0);

  assign bus.out_strobe = strobe;

  strobe_pacer #(
    .W (CNT_W)
  ) u_pacer (
    .clk       (clk),
    .rst       (rst),
    .clr       (kill),
    .go        (go),
    .setup_len (SETUP_L),
    .high_len  (HIGH_L),
    .strobe    (strobe),
    .finished  (finished)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      byte_count    <= '0;
    end else if (kill) begin
      state         <= S_IDLE;
      bus.mem_rd_en <= 1'b0;
      busy          <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr          <= base_addr;
            bus.mem_addr  <= base_addr;
            bus.mem_rd_en <= 1'b1;
            byte_count    <= '0;
            done          <= 1'b0;
            busy          <= 1'b1;
            state         <= S_READ;
          end
        end
        S_READ: begin
          bus.mem_rd_en <= 1'b0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (rd_byte == '0) begin
            state <= S_FIN;
          end else begin
            bus.out_data <= rd_byte;
            state        <= S_SETUP;
          end
        end
        // Pacer owns the windows; a 1-cycle high window
        // can finish before the FSM reaches S_HIGH.
        S_SETUP, S_HIGH: begin
          if (finished) begin
            byte_count <= byte_count + CNT_W'(1);
            addr       <= next_addr;
            if (is_last(byte_count, MAX_L)) begin
              state <= S_FIN;
            end else begin
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= next_addr;
              state         <= S_READ;
            end
          end else if (strobe) begin
            state <= S_HIGH;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: default instance
// plus a MAX_LEN=4 instance sharing one byte memory.
module tb_mem_dump_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base_addr = '0;
  logic        busy, done;
  logic [15:0] byte_count;

  logic        start2 = 1'b0;
  logic        abort2 = 1'b0;
  logic [31:0] base2 = '0;
  logic        busy2, done2;
  logic [15:0] bc2;

  mem_dump_streamer_if #(.ADDR_W(32), .DATA_W(32)) m1 ();
  mem_dump_streamer_if #(.ADDR_W(32), .DATA_W(32)) m2 ();

  mem_dump_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .bus        (m1),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  mem_dump_streamer #(.MAX_LEN(4)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
    .abort      (abort2),
    .base_addr  (base2),
    .bus        (m2),
    .busy       (busy2),
    .done       (done2),
    .byte_count (bc2)
  );

  logic [7:0]  mem_b [256];
  logic [31:0] aq1 [$];
  logic [31:0] aq2 [$];
  logic [7:0]  sq1 [$];
  logic [7:0]  sq2 [$];
  logic        s1_q = 1'b0;
  logic        s2_q = 1'b0;
  int checks = 0;
  int errors = 0;

  // Synchronous read memory; junk in upper bits.
  always @(posedge clk) begin
    if (m1.mem_rd_en)
      m1.mem_rdata <= {16'hC300, 8'h5A, mem_b[m1.mem_addr[7:0]]};
    if (m2.mem_rd_en)
      m2.mem_rdata <= {16'hC300, 8'h5A, mem_b[m2.mem_addr[7:0]]};
  end

  always @(posedge clk) begin
    s1_q <= m1.out_strobe;
    s2_q <= m2.out_strobe;
    if (m1.out_strobe && !s1_q) sq1.push_back(m1.out_data);
    if (m2.out_strobe && !s2_q) sq2.push_back(m2.out_data);
    if (m1.mem_rd_en) aq1.push_back(m1.mem_addr);
    if (m2.mem_rd_en) aq2.push_back(m2.mem_addr);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int which,
                           input int maxc,
                           input string tag);
    int n = 0;
    while ((which == 1 ? busy : busy2) && n < maxc) begin
      tick(1);
      n++;
    end
    chk({tag, "_timeout"}, 32'(which == 1 ? busy : busy2), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"},  32'(m1.mem_rd_en), 0);
    chk({tag, "_addr"},   m1.mem_addr, 0);
    chk({tag, "_data"},   32'(m1.out_data), 0);
    chk({tag, "_strobe"}, 32'(m1.out_strobe), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_done"},   32'(done), 0);
    chk({tag, "_count"},  32'(byte_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
    tick(2);
    chk_zero("reset");
    rst = 1'b0;
    tick(1);

    // "HI\0"; abort with start in IDLE must not block it
    mem_b[8'h10] = 8'h48;
    mem_b[8'h11] = 8'h49;
    mem_b[8'h12] = 8'h00;
    sq1.delete(); aq1.delete();
    base_addr = 32'h10; start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("hi_busy", 32'(busy), 1);
    wait_idle(1, 200, "hi");
    chk("hi_nstb",  sq1.size(), 2);
    chk("hi_stb0",  32'(sq1[0]), 32'h48);
    chk("hi_stb1",  32'(sq1[1]), 32'h49);
    chk("hi_nrd",   aq1.size(), 3);
    chk("hi_rd0",   aq1[0], 32'h10);
    chk("hi_rd1",   aq1[1], 32'h11);
    chk("hi_rd2",   aq1[2], 32'h12);
    chk("hi_count", 32'(byte_count), 2);
    chk("hi_done",  32'(done), 1);
    tick(2);

    // exact timing for one byte 0x7E
    mem_b[8'h20] = 8'h7E;
    mem_b[8'h21] = 8'h00;
    base_addr = 32'h20; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t1_rd_en",   32'(m1.mem_rd_en), 1);
    chk("t1_addr",    m1.mem_addr, 32'h20);
    chk("t1_done",    32'(done), 0);
    tick(1);
    chk("t2_rd_en",   32'(m1.mem_rd_en), 0);
    tick(1);
    chk("t3_data",    32'(m1.out_data), 32'h7E);
    chk("t3_strobe",  32'(m1.out_strobe), 0);
    tick(3);
    chk("t6_strobe",  32'(m1.out_strobe), 0);
    tick(1);
    chk("t7_strobe",  32'(m1.out_strobe), 1);
    tick(3);
    chk("t10_strobe", 32'(m1.out_strobe), 1);
    tick(1);
    chk("t11_strobe", 32'(m1.out_strobe), 0);
    wait_idle(1, 50, "t");
    chk("t_count",    32'(byte_count), 1);
    chk("t_done",     32'(done), 1);
    chk("t_data",     32'(m1.out_data), 32'h7E);
    tick(2);

    // MAX_LEN=4 instance, no terminator in range
    for (int i = 0; i < 6; i++) mem_b[8'h30 + i] = 8'(8'h41 + i);
    sq2.delete(); aq2.delete();
    base2 = 32'h30; start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    wait_idle(2, 200, "max");
    chk("max_nstb",  sq2.size(), 4);
    chk("max_stb0",  32'(sq2[0]), 32'h41);
    chk("max_stb3",  32'(sq2[3]), 32'h44);
    chk("max_nrd",   aq2.size(), 4);
    chk("max_rd3",   aq2[3], 32'h33);
    chk("max_count", 32'(bc2), 4);
    chk("max_done",  32'(done2), 1);
    tick(2);

    // abort during 2nd byte SETUP; stray start ignored
    mem_b[8'h40] = 8'h11;
    mem_b[8'h41] = 8'h22;
    mem_b[8'h42] = 8'h00;
    sq1.delete(); aq1.delete();
    base_addr = 32'h40; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    base_addr = 32'h80; start = 1'b1;
    tick(1);
    start = 1'b0; base_addr = 32'h40;
    tick(9);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ab_busy",   32'(busy), 0);
    chk("ab_strobe", 32'(m1.out_strobe), 0);
    chk("ab_rd_en",  32'(m1.mem_rd_en), 0);
    chk("ab_done",   32'(done), 0);
    chk("ab_count",  32'(byte_count), 1);
    chk("ab_data",   32'(m1.out_data), 32'h22);
    chk("ab_nrd",    aq1.size(), 2);
    chk("ab_rd1",    aq1[1], 32'h41);
    chk("ab_nstb",   sq1.size(), 1);
    tick(3);
    chk("ab_idle",   32'(busy), 0);
    chk("ab_nrd2",   aq1.size(), 2);

    // reset in HIGH of 2nd byte, then restart elsewhere
    mem_b[8'h50] = 8'h31;
    mem_b[8'h51] = 8'h32;
    mem_b[8'h52] = 8'h33;
    mem_b[8'h53] = 8'h00;
    base_addr = 32'h50; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(17);
    chk("rh_strobe", 32'(m1.out_strobe), 1);
    chk("rh_count",  32'(byte_count), 1);
    rst = 1'b1;
    tick(1);
    chk_zero("rh_reset");
    rst = 1'b0;
    mem_b[8'h60] = 8'h77;
    mem_b[8'h61] = 8'h00;
    sq1.delete(); aq1.delete();
    base_addr = 32'h60; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(1, 100, "rs");
    chk("rs_rd0",   aq1[0], 32'h60);
    chk("rs_nrd",   aq1.size(), 2);
    chk("rs_stb0",  32'(sq1[0]), 32'h77);
    chk("rs_count", 32'(byte_count), 1);
    chk("rs_done",  32'(done), 1);
    tick(2);

    // address wrap at the top of the space
    mem_b[8'hFF] = 8'h55;
    mem_b[8'h00] = 8'h66;
    mem_b[8'h01] = 8'h00;
    sq1.delete(); aq1.delete();
    base_addr = 32'hFFFF_FFFF; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(1, 100, "wr");
    chk("wr_rd0",   aq1[0], 32'hFFFF_FFFF);
    chk("wr_rd1",   aq1[1], 32'h0000_0000);
    chk("wr_rd2",   aq1[2], 32'h0000_0001);
    chk("wr_stb0",  32'(sq1[0]), 32'h55);
    chk("wr_stb1",  32'(sq1[1]), 32'h66);
    chk("wr_count", 32'(byte_count), 2);
    chk("wr_done",  32'(done), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
